// File: rtl/hdmi_pkg.sv
// Shared types and constants for the HDMI/DVI output path: sync bit layout,
// raster timing description and the TMDS control-period code words.
package hdmi_pkg;

  typedef logic [1:0] vh_t;
  localparam int VH_VSYNC = 1;
  localparam int VH_HSYNC = 0;

  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [10:0] v_active;
    logic [10:0] v_fp;
    logic [10:0] v_sync;
    logic [10:0] v_bp;
    logic        hs_pol;
    logic        vs_pol;
  } timing_t;

  localparam timing_t VGA_640x480 = '{
    h_active: 12'd640, h_fp: 12'd16, h_sync: 12'd96, h_bp: 12'd48,
    v_active: 11'd480, v_fp: 11'd10, v_sync: 11'd2,  v_bp: 11'd33,
    hs_pol:   1'b0,    vs_pol: 1'b0
  };

  // Control-period symbols indexed by {c1,c0}; shared with tmds_encoder.
  localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

endpackage

// File: rtl/sync_delay_line.sv
// Depth-N, width-W shift register that only advances when en=1; N=0 is a wire.
// Used to align de/vh (or pixel data) with a fixed-latency pixel source.
module sync_delay_line #(
  parameter int           N       = 1,
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  if (N == 0) begin : g_bypass
    logic unused_ctl;
    assign unused_ctl = ^{clk, rst, en};
    assign dout       = din;
  end else begin : g_shift
    logic [W-1:0] stage_q [N];
    logic [W-1:0] stage_d [N];

    always_comb begin
      stage_d = stage_q;
      if (en) begin
        stage_d[0] = din;
        for (int i = 1; i < N; i++) stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < N; i++) stage_q[i] <= RST_VAL;
      end else begin
        stage_q <= stage_d;
      end
    end

    assign dout = stage_q[N-1];
  end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel request/coordinates for the pixel source and
// de/vh for the TMDS encoders, the latter delayed LEAD cycles to match source latency.
module video_timing_gen
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE = int'(VGA_640x480.h_active),
  parameter int H_FP     = int'(VGA_640x480.h_fp),
  parameter int H_SYNC   = int'(VGA_640x480.h_sync),
  parameter int H_BP     = int'(VGA_640x480.h_bp),
  parameter int V_ACTIVE = int'(VGA_640x480.v_active),
  parameter int V_FP     = int'(VGA_640x480.v_fp),
  parameter int V_SYNC   = int'(VGA_640x480.v_sync),
  parameter int V_BP     = int'(VGA_640x480.v_bp),
  parameter int HS_POL   = int'(VGA_640x480.hs_pol),
  parameter int VS_POL   = int'(VGA_640x480.vs_pol),
  parameter int LEAD     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        px_req,
  output logic [11:0] x,
  output logic [10:0] y,
  output logic        line_start,
  output logic        frame_start,
  output logic        de,
  output vh_t         vh
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 4096) begin : g_chk_h
    $error("video_timing_gen: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > 2048) begin : g_chk_v
    $error("video_timing_gen: V_TOTAL exceeds 2048");
  end
  if (LEAD < 0 || LEAD > 4) begin : g_chk_lead
    $error("video_timing_gen: LEAD must be in 0..4");
  end

  // 13-bit bounds so a region ending exactly at 4096/2048 still compares correctly.
  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [12:0] H_ACT_END = 13'(H_ACTIVE);
  localparam logic [12:0] HS_BEG    = 13'(H_ACTIVE + H_FP);
  localparam logic [12:0] HS_END    = 13'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [12:0] V_ACT_END = 13'(V_ACTIVE);
  localparam logic [12:0] VS_BEG    = 13'(V_ACTIVE + V_FP);
  localparam logic [12:0] VS_END    = 13'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic       HS_ACT  = (HS_POL != 0);
  localparam logic       VS_ACT  = (VS_POL != 0);
  localparam logic [2:0] S0_IDLE = {1'b0, ~VS_ACT, ~HS_ACT};

  logic [11:0] hcnt_q, hcnt_d;
  logic [11:0] vcnt_q, vcnt_d;
  logic        px_req_q, px_req_d;
  logic [11:0] x_q, x_d;
  logic [10:0] y_q, y_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [2:0]  s0_q, s0_d;
  logic        active, hs0, vs0;
  logic [2:0]  dly_out;

  always_comb begin
    active = ({1'b0, hcnt_q} < H_ACT_END) && ({1'b0, vcnt_q} < V_ACT_END);
    hs0 = ({1'b0, hcnt_q} >= HS_BEG && {1'b0, hcnt_q} < HS_END) ? HS_ACT : ~HS_ACT;
    vs0 = ({1'b0, vcnt_q} >= VS_BEG && {1'b0, vcnt_q} < VS_END) ? VS_ACT : ~VS_ACT;

    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    px_req_d      = px_req_q;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    s0_d          = s0_q;

    if (en) begin
      hcnt_d = (hcnt_q == H_LAST) ? 12'd0 : hcnt_q + 12'd1;
      if (hcnt_q == H_LAST) begin
        vcnt_d = (vcnt_q == V_LAST) ? 12'd0 : vcnt_q + 12'd1;
      end
      px_req_d      = active;
      x_d           = active ? hcnt_q : 12'd0;
      y_d           = active ? vcnt_q[10:0] : 11'd0;
      line_start_d  = active && (hcnt_q == 12'd0);
      frame_start_d = active && (hcnt_q == 12'd0) && (vcnt_q == 12'd0);
      s0_d          = {active, vs0, hs0};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      px_req_q      <= 1'b0;
      x_q           <= '0;
      y_q           <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      s0_q          <= S0_IDLE;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      px_req_q      <= px_req_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      s0_q          <= s0_d;
    end
  end

  sync_delay_line #(
    .N       (LEAD),
    .W       (3),
    .RST_VAL (S0_IDLE)
  ) u_sync_dly (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (s0_q),
    .dout (dly_out)
  );

  assign px_req      = px_req_q;
  assign x           = x_q;
  assign y           = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign de          = dly_out[2];
  assign vh          = dly_out[1:0];

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: four small-raster instances (LEAD 1/0/4, inverted
// polarity) compared each cycle against an arithmetic raster model.
module tb_video_timing_gen;

  localparam int HT    = 10;
  localparam int VT    = 7;
  localparam int FRAME = HT * VT;
  localparam int ND    = 4;

  typedef logic [28:0] obs_t;  // {px_req, x[11:0], y[10:0], line_start, frame_start, de, vh[1:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  logic        px [ND];
  logic [11:0] xo [ND];
  logic [10:0] yo [ND];
  logic        ls [ND];
  logic        fs [ND];
  logic        deo[ND];
  logic [1:0]  vho[ND];
  obs_t        obs[ND];

  int checks = 0;
  int errors = 0;
  int step   = 0;  // en=1 edges since reset release

  always_comb begin
    for (int i = 0; i < ND; i++) obs[i] = {px[i], xo[i], yo[i], ls[i], fs[i], deo[i], vho[i]};
  end

  video_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .LEAD(1)) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .px_req(px[0]), .x(xo[0]), .y(yo[0]),
    .line_start(ls[0]), .frame_start(fs[0]), .de(deo[0]), .vh(vho[0]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .LEAD(0)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .px_req(px[1]), .x(xo[1]), .y(yo[1]),
    .line_start(ls[1]), .frame_start(fs[1]), .de(deo[1]), .vh(vho[1]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(0), .VS_POL(0), .LEAD(4)) u_dut2 (
    .clk(clk), .rst(rst), .en(en), .px_req(px[2]), .x(xo[2]), .y(yo[2]),
    .line_start(ls[2]), .frame_start(fs[2]), .de(deo[2]), .vh(vho[2]));

  video_timing_gen #(.H_ACTIVE(4), .H_FP(2), .H_SYNC(3), .H_BP(1), .V_ACTIVE(3), .V_FP(1),
    .V_SYNC(2), .V_BP(1), .HS_POL(1), .VS_POL(1), .LEAD(1)) u_dut3 (
    .clk(clk), .rst(rst), .en(en), .px_req(px[3]), .x(xo[3]), .y(yo[3]),
    .line_start(ls[3]), .frame_start(fs[3]), .de(deo[3]), .vh(vho[3]));

  function automatic int lead_of(int d);
    case (d)
      1:       return 0;
      2:       return 4;
      default: return 1;
    endcase
  endfunction

  // Expected outputs of instance d after k en=1 edges; edge j samples raster position j-1.
  function automatic obs_t model(int d, int k);
    obs_t r;
    int   n, hc, vc, m;
    logic pol;
    pol = (d == 3);
    r   = '0;
    if (k >= 1) begin
      n  = (k - 1) % FRAME;
      hc = n % HT;
      vc = n / HT;
      if (hc < 4 && vc < 3) begin
        r[28]    = 1'b1;
        r[27:16] = 12'(hc);
        r[15:5]  = 11'(vc);
        r[4]     = (hc == 0);
        r[3]     = (hc == 0 && vc == 0);
      end
    end
    m = k - lead_of(d);
    r[2] = 1'b0;
    r[1] = ~pol;
    r[0] = ~pol;
    if (m >= 1) begin
      n  = (m - 1) % FRAME;
      hc = n % HT;
      vc = n / HT;
      r[2] = (hc < 4 && vc < 3);
      r[1] = (vc >= 4 && vc < 6) ? pol : ~pol;
      r[0] = (hc >= 6 && hc < 9) ? pol : ~pol;
    end
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    step = 0;
  endtask

  task automatic run_cycle(input logic en_v);
    en = en_v;
    @(posedge clk);
    if (en_v) step++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    obs_t e;
    rst = 1'b1;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      e = model(d, 0);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h want %h", d, obs[d], e);
      end
    end
    rst  = 1'b0;
    step = 0;
  endtask

  task automatic test_small_timing();
    obs_t e;
    int   n_px, n_fs, n_ls;
    n_px = 0;
    n_fs = 0;
    n_ls = 0;
    do_reset();
    for (int c = 0; c < 3 * FRAME; c++) begin
      run_cycle(1'b1);
      for (int d = 0; d < ND; d++) begin
        e = model(d, step);
        checks++;
        if (obs[d] !== e) begin
          errors++;
          $display("FAIL raster dut%0d step %0d got %h want %h", d, step, obs[d], e);
        end
      end
      if (px[0]) n_px++;
      if (ls[0]) n_ls++;
      if (fs[0]) begin
        n_fs++;
        checks++;
        if (xo[0] !== 12'd0 || yo[0] !== 11'd0) begin
          errors++;
          $display("FAIL frame_start_origin step %0d got x=%0d y=%0d want 0,0", step, xo[0], yo[0]);
        end
      end
    end
    checks++;
    if (n_px != 36) begin
      errors++;
      $display("FAIL px_req_count got %0d want 36", n_px);
    end
    checks++;
    if (n_fs != 3) begin
      errors++;
      $display("FAIL frame_start_count got %0d want 3", n_fs);
    end
    checks++;
    if (n_ls != 9) begin
      errors++;
      $display("FAIL line_start_count got %0d want 9", n_ls);
    end
  endtask

  task automatic test_random_en();
    obs_t e;
    obs_t prev[ND];
    logic en_v;
    do_reset();
    for (int d = 0; d < ND; d++) prev[d] = obs[d];
    for (int c = 0; c < 400; c++) begin
      en_v = 1'($urandom_range(0, 1));
      run_cycle(en_v);
      for (int d = 0; d < ND; d++) begin
        e = model(d, step);
        checks++;
        if (obs[d] !== e) begin
          errors++;
          $display("FAIL random_en dut%0d step %0d got %h want %h", d, step, obs[d], e);
        end
        if (!en_v) begin
          checks++;
          if (obs[d] !== prev[d]) begin
            errors++;
            $display("FAIL stall_hold dut%0d got %h want %h", d, obs[d], prev[d]);
          end
        end
        prev[d] = obs[d];
      end
    end
  endtask

  task automatic test_mid_reset();
    obs_t e;
    logic found;
    found = 1'b0;
    do_reset();
    for (int c = 0; c < 100 && !found; c++) begin
      run_cycle(1'b1);
      if (xo[0] == 12'd2 && yo[0] == 11'd1 && deo[0] == 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL mid_reset_reach got none want x=2 y=1 de=1 within 100 cycles");
    end
    rst = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      e = model(d, 0);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL async_reset dut%0d got %h want %h", d, obs[d], e);
      end
    end
    @(negedge clk);
    rst  = 1'b0;
    step = 0;
    run_cycle(1'b1);
    for (int d = 0; d < ND; d++) begin
      e = model(d, step);
      checks++;
      if (obs[d] !== e) begin
        errors++;
        $display("FAIL restart dut%0d got %h want %h", d, obs[d], e);
      end
    end
    checks++;
    if (fs[0] !== 1'b1 || xo[0] !== 12'd0 || yo[0] !== 11'd0) begin
      errors++;
      $display("FAIL restart_origin got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", fs[0], xo[0], yo[0]);
    end
  endtask

  initial begin
    test_reset();
    test_small_timing();
    test_random_en();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
